mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that acts as the peripheral for the data-memory path's MMIO write-control bundle and MMIO read-data return. It decodes a 16-byte register window and queues bytes written by the core in a small FIFO. It serialises them as 8N1 frames on `tx` using a programmable baud divisor. Read data is registered, giving one-cycle latency to match the RAM read path it is multiplexed against.

## Interface

- `base_addr`, default 32'h00010000: byte address of the register window; must be 16-byte aligned.
- `default_divisor`, default 16'd434: reset value of BAUD_DIV, in clock cycles per bit.
- `fifo_depth`, default 8: TX FIFO entries; power of two, at least 2. Used only with MMIO_UART_TX_FIFO_EN.
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `mmio_control`  input  mem_write_control_t: fields `addr`, `value`, `width` and `enable` from the memory stage. `addr` is valid every cycle, including reads.
- `mmio_r_data`  output  XLEN: registered read data for the address presented in the previous cycle.
- `tx`  output  1: serial line, idle high.

## Operation

Register decode:
- A register is selected when `addr` is in [base_addr, base_addr+16). The offset is `addr[3:2]`; `addr[1:0]` is ignored.
- **0x0 TXDATA** (write)
  - A write with `enable` at any width pushes `value[7:0]`.
  - If the FIFO is full, the byte is dropped and OVERRUN is set.
  - Reads return 0.
- **0x4 STATUS** (read)
  - bit0 FULL, bit1 EMPTY, bit2 BUSY (FSM not IDLE), bit3 OVERRUN (sticky).
  - bits[15:8] hold the FIFO count; all other bits read 0.
  - A WIDTH_WORD write with `value[3]`=1 clears OVERRUN. Other writes are ignored.
- **0x8 BAUD_DIV** (read/write)
  - A WIDTH_WORD write loads `value[15:0]`; byte and halfword writes are ignored.
  - A written value of 0 is stored as 1.
  - Reads return the value zero-extended.
- **0xC** and all addresses outside the window: reads return 0, writes are ignored.

FIFO:
- Circular buffer with read/write pointers and a count.
- Push is qualified against the count before that edge's pop. A push while full is dropped even if a pop occurs in the same cycle.
- Push while empty has no bypass. The byte is visible to the FSM on the following cycle.

Transmit FSM (states IDLE, START, DATA, STOP):
- **IDLE**: `tx`=1. If the FIFO is non-empty:
  - pop the head into the shift register;
  - latch BAUD_DIV into the frame divisor;
  - go to START.
- **START**: `tx`=0 for the frame-divisor cycles, then go to DATA with bit index 0.
- **DATA**: `tx`=shift[0] for the frame-divisor cycles, then shift right.
  - After bit index 7 completes, go to STOP.
- **STOP**: `tx`=1 for the frame-divisor cycles. Then:
  - if the FIFO is non-empty, pop, latch the divisor and go directly to START, with no idle gap;
  - otherwise go to IDLE.
- A BAUD_DIV write takes effect only at the next frame start. The frame in flight keeps its latched divisor.

## Timing

- Reset values:
  - `tx`=1, `mmio_r_data`=0;
  - FSM IDLE, FIFO empty (count 0, pointers 0);
  - OVERRUN=0, BAUD_DIV=default_divisor.
- Read latency is 1 cycle. `mmio_r_data` at edge N+1 reflects register state sampled at edge N for `addr` at edge N. Updates made at that same edge are not visible.
- Write to TXDATA at edge N:
  - STATUS read issued in cycle N+1 shows the new count;
  - FSM leaves IDLE at edge N+1;
  - `tx` falls after edge N+1; `tx` is a registered output.
- Frame length is 10 × divisor cycles. Back-to-back frames from a non-empty FIFO are contiguous.
- Reset asserted mid-frame returns `tx` high immediately and discards the FIFO contents.

## Configuration

- MMIO_UART_TX_FIFO_EN defined: FIFO of `fifo_depth` entries as described above.
- Macro undefined:
  - `fifo_depth` is ignored and a single holding register replaces the FIFO (depth 1, count 0 or 1).
  - All other behaviour is identical, including the overrun rule: a push while holding is dropped even if the FSM pops in the same cycle.

## Test plan

- Reset check: release reset, then read STATUS → 0x00000002 (EMPTY), BAUD_DIV → 434, `tx`=1.
- Single frame: word-write BAUD_DIV=4, then write TXDATA=0xA5.
  - `tx` is low for 4 cycles.
  - Data bits follow at 4 cycles each, LSB first: 1,0,1,0,0,1,0,1.
  - `tx` then stays high for 4 cycles; BUSY clears 40 cycles after the frame starts.
- Back-to-back: with divisor 2, write 0x00 then 0xFF on consecutive cycles.
  - Frames are contiguous (40 cycles total).
  - STATUS count reads 1 during the first frame.
- Overrun (FIFO enabled, depth 8, divisor 100): write 10 bytes back-to-back.
  - First byte is popped at once, next 8 fill the FIFO, the 10th is dropped.
  - STATUS reads FULL=1, OVERRUN=1, count=8.
  - Word-write STATUS=0x8 → OVERRUN clears.
- Width and decode: halfword write to BAUD_DIV leaves it unchanged.
  - Read at base+0xC and at base+0x10 → 0.
  - Byte write 0x1234 to TXDATA transmits 0x34.
- Divisor change mid-frame: write BAUD_DIV=8 during a divisor-4 frame.
  - Current frame completes at 4 cycles per bit; the next frame uses 8.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on a 16-byte register window (TXDATA, STATUS, BAUD_DIV).
// Define MMIO_UART_TX_FIFO_EN for a fifo_depth-entry TX FIFO; otherwise a single holding register is used.
package mmio_uart_tx_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        mem_width_t      width;
        logic            enable;
    } mem_write_control_t;
endpackage

module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] base_addr       = 32'h0001_0000,
    parameter logic [15:0] default_divisor = 16'd434,
    parameter int          fifo_depth      = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  mem_write_control_t mmio_control,
    output logic [XLEN-1:0]    mmio_r_data,
    output logic               tx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    logic        sel_s;
    logic [1:0]  off_s;
    logic        wr_txdata_s;
    logic        wr_status_s;
    logic        wr_baud_s;
    logic        full_s;
    logic        empty_s;
    logic        busy_s;
    logic        push_s;
    logic        pop_s;
    logic        bit_end_s;
    logic [7:0]  head_s;
    logic [7:0]  count_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    tx_state_t   state_r;
    logic        tx_r;
    logic        overrun_r;
    logic [15:0] baud_r;
    logic [15:0] frame_div_r;
    logic [15:0] bit_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic [31:0] rdata_r;

    assign unused_s = ^{mmio_control.addr[1:0], mmio_control.value[31:16], (fifo_depth > 0)};

    // Address decode, write strobes and transmitter handshake
    always_comb begin
        sel_s       = (mmio_control.addr[31:4] == base_addr[31:4]);
        off_s       = mmio_control.addr[3:2];
        wr_txdata_s = mmio_control.enable && sel_s && (off_s == REG_TXDATA);
        wr_status_s = mmio_control.enable && sel_s && (off_s == REG_STATUS) &&
                      (mmio_control.width == WIDTH_WORD);
        wr_baud_s   = mmio_control.enable && sel_s && (off_s == REG_BAUD) &&
                      (mmio_control.width == WIDTH_WORD);
        push_s      = wr_txdata_s && !full_s;
        busy_s      = (state_r != ST_IDLE);
        bit_end_s   = (bit_cnt_r == (frame_div_r - 16'd1));
        // STOP pops only on its final cycle so back-to-back frames have no idle gap
        pop_s       = !empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s));
    end

    // Read-data mux, registered below for one-cycle latency
    always_comb begin
        rdata_s = 32'd0;
        if (sel_s) begin
            case (off_s)
                REG_STATUS: rdata_s = {16'd0, count_s, 4'd0, overrun_r, busy_s, empty_s, full_s};
                REG_BAUD:   rdata_s = {16'd0, baud_r};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Control registers and registered read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r   <= 32'd0;
            overrun_r <= 1'b0;
            baud_r    <= default_divisor;
        end else begin
            rdata_r <= rdata_s;
            if (wr_txdata_s && full_s) begin
                overrun_r <= 1'b1;
            end else if (wr_status_s && mmio_control.value[3]) begin
                overrun_r <= 1'b0;
            end
            if (wr_baud_s) begin
                baud_r <= (mmio_control.value[15:0] == 16'd0) ? 16'd1 : mmio_control.value[15:0];
            end
        end
    end

`ifdef MMIO_UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(fifo_depth);
    localparam int CNT_W = $clog2(fifo_depth + 1);

    logic [7:0]       mem_r [fifo_depth];
    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] cnt_r;

    assign full_s  = (cnt_r == CNT_W'(fifo_depth));
    assign empty_s = (cnt_r == CNT_W'(1'b0));
    assign count_s = 8'(cnt_r);
    assign head_s  = mem_r[rptr_r];

    // Circular TX FIFO; full is judged before this edge's pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < fifo_depth; i++) begin
                mem_r[i] <= 8'd0;
            end
            wptr_r <= PTR_W'(1'b0);
            rptr_r <= PTR_W'(1'b0);
            cnt_r  <= CNT_W'(1'b0);
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= mmio_control.value[7:0];
                wptr_r        <= wptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1'b1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
`else
    logic [7:0] hold_r;
    logic       hold_valid_r;

    assign full_s  = hold_valid_r;
    assign empty_s = !hold_valid_r;
    assign count_s = {7'd0, hold_valid_r};
    assign head_s  = hold_r;

    // Single holding register; push and pop are mutually exclusive by construction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_r       <= 8'd0;
            hold_valid_r <= 1'b0;
        end else if (push_s) begin
            hold_r       <= mmio_control.value[7:0];
            hold_valid_r <= 1'b1;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end
    end
`endif

    // Transmit FSM with registered serial output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            tx_r        <= 1'b1;
            shift_r     <= 8'd0;
            bit_idx_r   <= 3'd0;
            bit_cnt_r   <= 16'd0;
            frame_div_r <= 16'd1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                    if (pop_s) begin
                        shift_r     <= head_s;
                        frame_div_r <= baud_r;
                        bit_cnt_r   <= 16'd0;
                        state_r     <= ST_START;
                        tx_r        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        tx_r      <= shift_r[0];
                        bit_idx_r <= 3'd0;
                        bit_cnt_r <= 16'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= 16'd0;
                        if (pop_s) begin
                            shift_r     <= head_s;
                            frame_div_r <= baud_r;
                            state_r     <= ST_START;
                            tx_r        <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign mmio_r_data = rdata_r;
    assign tx          = tx_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-level reference model checked every cycle plus directed literals.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef MMIO_UART_TX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic               clock   = 1'b0;
    logic               reset_n = 1'b0;
    mem_write_control_t ctl;
    logic [31:0]        r_data;
    logic               tx;
    int                 errors  = 0;
    int                 checks  = 0;

    mmio_uart_tx #(
        .base_addr       (BASE),
        .default_divisor (16'd434),
        .fifo_depth      (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mmio_control (ctl),
        .mmio_r_data  (r_data),
        .tx           (tx)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus the frame in flight, described by elapsed time
    logic [7:0]  q[$];
    logic        m_active = 1'b0;
    logic [7:0]  m_byte   = 8'd0;
    int          m_div    = 1;
    int          m_t      = 0;
    logic [15:0] m_baud   = 16'd434;
    logic        m_ovr    = 1'b0;
    logic [31:0] m_rdata  = 32'd0;
    logic        m_tx     = 1'b1;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < BASE || a >= BASE + 32'd16) return 32'd0;
        case ((a - BASE) / 32'd4)
            32'd1:   return {16'd0, 8'(q.size()), 4'd0, m_ovr, m_active, (q.size() == 0), (q.size() >= CAP)};
            32'd2:   return {16'd0, m_baud};
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            q.delete();
            m_active = 1'b0; m_byte = 8'd0; m_div = 1; m_t = 0;
            m_baud = 16'd434; m_ovr = 1'b0; m_rdata = 32'd0; m_tx = 1'b1;
        end else begin : step
            int          size0;
            int          baud0;
            int          idx;
            logic        do_pop;
            logic        do_push;
            logic [31:0] a;
            size0   = q.size();
            baud0   = int'(m_baud);
            a       = ctl.addr;
            m_rdata = m_read(a);
            do_pop  = 1'b0;
            do_push = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == 10 * m_div) begin
                    m_active = 1'b0;
                    do_pop   = (size0 > 0);
                end
            end else begin
                do_pop = (size0 > 0);
            end
            if (ctl.enable && a >= BASE && a < BASE + 32'd16) begin
                idx = int'((a - BASE) / 32'd4);
                if (idx == 0) begin
                    if (size0 < CAP) do_push = 1'b1;
                    else m_ovr = 1'b1;
                end else if (idx == 1) begin
                    if (ctl.width == WIDTH_WORD && ctl.value[3]) m_ovr = 1'b0;
                end else if (idx == 2) begin
                    if (ctl.width == WIDTH_WORD)
                        m_baud = (ctl.value[15:0] == 16'd0) ? 16'd1 : ctl.value[15:0];
                end
            end
            if (do_pop) begin
                m_byte   = q.pop_front();
                m_div    = baud0;
                m_t      = 0;
                m_active = 1'b1;
            end
            if (do_push) q.push_back(ctl.value[7:0]);
            if (!m_active) m_tx = 1'b1;
            else if (m_t / m_div == 0) m_tx = 1'b0;
            else if (m_t / m_div <= 8) m_tx = m_byte[m_t / m_div - 1];
            else m_tx = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clock);
        check("model_tx", {31'd0, tx}, {31'd0, m_tx});
        check("model_rdata", r_data, m_rdata);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] v, input mem_width_t w);
        ctl.addr = a; ctl.value = v; ctl.width = w; ctl.enable = 1'b1;
        @(negedge clock);
        ctl.enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ctl.addr = a; ctl.enable = 1'b0;
        @(negedge clock);
        d = r_data;
    endtask

    task automatic idle(input int n);
        ctl.enable = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  fb;
        ctl = '0;
        repeat (3) @(negedge clock);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdata", r_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        rd(BASE + 32'd4, d); check("reset_status", d, 32'h0000_0002);
        rd(BASE + 32'd8, d); check("reset_baud", d, 32'd434);
        check("idle_tx", {31'd0, tx}, 32'd1);

        // Single 0xA5 frame at divisor 4
        wr(BASE + 32'd8, 32'd4, WIDTH_WORD);
        wr(BASE, 32'h0000_00A5, WIDTH_WORD);
        fb = 10'b11_0100_1010;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check("a5_frame_bit", {31'd0, tx}, {31'd0, fb[k / 4]});
        end
        rd(BASE + 32'd4, d); check("a5_busy_last_cycle", d, 32'h0000_0006);
        rd(BASE + 32'd4, d); check("a5_idle_after", d, 32'h0000_0002);

        // Back-to-back frames at divisor 2
        wr(BASE + 32'd8, 32'd2, WIDTH_WORD);
        wr(BASE, 32'h00, WIDTH_BYTE);
`ifdef MMIO_UART_TX_FIFO_EN
        wr(BASE, 32'hFF, WIDTH_BYTE);
        rd(BASE + 32'd4, d); check("b2b_count", d, 32'h0000_0104);
        idle(38);
`else
        idle(1);
        wr(BASE, 32'hFF, WIDTH_BYTE);
        rd(BASE + 32'd4, d); check("b2b_count", d, 32'h0000_0105);
        idle(37);
`endif
        rd(BASE + 32'd4, d); check("b2b_busy_at_40", d, 32'h0000_0006);
        rd(BASE + 32'd4, d); check("b2b_idle_after", d, 32'h0000_0002);

        // Overrun at divisor 100
        wr(BASE + 32'd8, 32'd100, WIDTH_WORD);
        for (int i = 0; i < CAP + 2; i++) wr(BASE, 32'h10 + 32'(i), WIDTH_BYTE);
`ifdef MMIO_UART_TX_FIFO_EN
        rd(BASE + 32'd4, d); check("ovr_status", d, 32'h0000_080D);
        wr(BASE + 32'd4, 32'h8, WIDTH_HALF);
        rd(BASE + 32'd4, d); check("ovr_half_no_clear", d, 32'h0000_080D);
        wr(BASE + 32'd4, 32'h8, WIDTH_WORD);
        rd(BASE + 32'd4, d); check("ovr_cleared", d, 32'h0000_0805);
`else
        rd(BASE + 32'd4, d); check("ovr_status", d, 32'h0000_010D);
        wr(BASE + 32'd4, 32'h8, WIDTH_HALF);
        rd(BASE + 32'd4, d); check("ovr_half_no_clear", d, 32'h0000_010D);
        wr(BASE + 32'd4, 32'h8, WIDTH_WORD);
        rd(BASE + 32'd4, d); check("ovr_cleared", d, 32'h0000_0105);
`endif

        // Reset during the start bit of a long frame
        idle(20);
        check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
        #2 reset_n = 1'b0;
        #1 check("mid_reset_tx_high", {31'd0, tx}, 32'd1);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        rd(BASE + 32'd4, d); check("post_reset_status", d, 32'h0000_0002);
        rd(BASE + 32'd8, d); check("post_reset_baud", d, 32'd434);

        // Width qualification and window decode
        wr(BASE + 32'd8, 32'd4, WIDTH_WORD);
        wr(BASE + 32'd8, 32'h10, WIDTH_HALF);
        wr(BASE + 32'd8, 32'h20, WIDTH_BYTE);
        wr(BASE + 32'h18, 32'd7, WIDTH_WORD);
        rd(BASE + 32'd8, d); check("baud_width_filter", d, 32'd4);
        rd(BASE + 32'hA, d); check("baud_low_addr_bits", d, 32'd4);
        wr(BASE + 32'hC, 32'h55, WIDTH_WORD);
        rd(BASE + 32'hC, d); check("reg_0xc_zero", d, 32'd0);
        rd(BASE + 32'h10, d); check("outside_0x10", d, 32'd0);
        rd(BASE + 32'h14, d); check("outside_0x14", d, 32'd0);
        rd(BASE - 32'd8, d); check("below_base", d, 32'd0);
        rd(BASE, d); check("txdata_reads_zero", d, 32'd0);
        wr(BASE, 32'h0000_1234, WIDTH_BYTE);
        fb = 10'b10_0110_1000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            check("byte_0x34_frame_bit", {31'd0, tx}, {31'd0, fb[k / 4]});
        end
        idle(2);

        // Divisor change while a frame is in flight
        wr(BASE, 32'h0F, WIDTH_BYTE);
        idle(3);
        wr(BASE + 32'd8, 32'd8, WIDTH_WORD);
        wr(BASE, 32'hF0, WIDTH_BYTE);
        idle(115);
        rd(BASE + 32'd4, d); check("divchg_busy_last", d, 32'h0000_0006);
        rd(BASE + 32'd4, d); check("divchg_idle_after", d, 32'h0000_0002);

        // Zero divisor is stored as one
        wr(BASE + 32'd8, 32'd0, WIDTH_WORD);
        rd(BASE + 32'd8, d); check("baud_zero_as_one", d, 32'd1);
        wr(BASE + 32'd8, 32'hFFFF_0003, WIDTH_WORD);
        rd(BASE + 32'd8, d); check("baud_upper_ignored", d, 32'd3);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
